// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: datapath width, reset/bubble defaults
// and the end-of-program drain FSM state encoding.
package rv_pipe_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage control inputs, instruction-memory data and
// IF/ID outputs. master = environment (hazard unit, execute, memory),
// slave = the fetch stage itself.
interface fetch_stage_if #(
    parameter int XLEN = rv_pipe_pkg::XLEN_DEF
);
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            pc_select;
    logic [XLEN-1:0] branch_jump_target;
    logic [XLEN-1:0] last_pc;
    logic [31:0]     InstrF;

    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] pc_plus4F;
    logic [XLEN-1:0] PCD;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] pc_plus4D;
    logic            drain_active;
    logic            halted;
    logic [31:0]     fetch_count;

    modport master (
        output StallF, StallD, FlushD, pc_select, branch_jump_target, last_pc, InstrF,
        input  PCF, pc_plus4F, PCD, InstrD, pc_plus4D, drain_active, halted, fetch_count
    );

    modport slave (
        input  StallF, StallD, FlushD, pc_select, branch_jump_target, last_pc, InstrF,
        output PCF, pc_plus4F, PCD, InstrD, pc_plus4D, drain_active, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous reset, flush to a bubble, stall to hold.
module if_id_reg
    import rv_pipe_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_plus4_o
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

    // Next contents: flush beats stall beats load.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (flush_i) begin
            pc_d       = '0;
            instr_d    = NOP_INSTR;
            pc_plus4_d = '0;
        end else if (!stall_i) begin
            pc_d       = pc_i;
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
        end
    end

    // Register update with synchronous reset to an empty bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux, IF/ID register and the
// end-of-program drain FSM that feeds bubbles before raising halted.
module fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter int          XLEN         = XLEN_DEF,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF,
    parameter int          DRAIN_CYCLES = 10
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    // Wide enough to hold DRAIN_CYCLES itself, so the final increment never wraps.
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    fetch_state_e    state_q, state_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic [31:0]     fetch_word;
    logic            accept_last;
    logic            ifid_stall;

    assign pc_plus4   = pcf_q + XLEN'(4);
    assign next_pc    = bus.pc_select ? bus.branch_jump_target : pc_plus4;
    assign fetch_word = (state_q == RUN) ? bus.InstrF : NOP_INSTR;

    // The final word only counts as fetched when it actually enters IF/ID
    // and is not being discarded by a redirect.
    assign accept_last = (pcf_q == bus.last_pc) && !bus.StallF && !bus.StallD
                         && !bus.FlushD && !bus.pc_select;

    // Once halted the decode stall is ignored so bubbles keep flowing.
    assign ifid_stall = bus.StallD && (state_q != HALT);

    // Next-state logic for the drain FSM, PC and fetch counter.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        pcf_d         = pcf_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            RUN: begin
                if (accept_last) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                // A redirect from an older branch still in flight wins over completion.
                if (bus.pc_select) begin
                    state_d     = RUN;
                    drain_cnt_d = '0;
                end else if (!bus.StallD) begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d     = RUN;
                drain_cnt_d = '0;
            end
        endcase

        // Redirects always land, even over a fetch stall.
        if ((state_q != HALT) && (bus.pc_select || !bus.StallF)) begin
            pcf_d = next_pc;
        end

        if ((state_q == RUN) && !bus.StallD && !bus.FlushD && (fetch_word != NOP_INSTR)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // State, PC and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            drain_cnt_q   <= '0;
            pcf_q         <= RESET_PC[XLEN-1:0];
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            pcf_q         <= pcf_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (bus.FlushD),
        .stall_i    (ifid_stall),
        .pc_i       (pcf_q),
        .instr_i    (fetch_word),
        .pc_plus4_i (pc_plus4),
        .pc_o       (bus.PCD),
        .instr_o    (bus.InstrD),
        .pc_plus4_o (bus.pc_plus4D)
    );

    assign bus.PCF          = pcf_q;
    assign bus.pc_plus4F    = pc_plus4;
    assign bus.drain_active = (state_q == DRAIN);
    assign bus.halted       = (state_q == HALT);
    assign bus.fetch_count  = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for straight-line fetch with a
// stall, drain and halt; hand sequences for redirects, drain abort and reset.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;

    fetch_stage_if #(.XLEN(32)) bus ();

    fetch_stage #(
        .XLEN         (32),
        .RESET_PC     (32'h0000_0000),
        .NOP_INSTR    (32'h0000_0000),
        .DRAIN_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: every address holds a distinct nonzero word.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h9300_0000 | {8'h00, a[23:0]};
    endfunction

    assign bus.InstrF = instr_of(bus.PCF);

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        sf, sd, fd, ps;
        logic [31:0] tgt;
        logic [31:0] pcf, pcd, instr;
        logic        drain, halted;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd,
                         input logic ps, input logic [31:0] tgt);
        bus.StallF             = sf;
        bus.StallD             = sd;
        bus.FlushD             = fd;
        bus.pc_select          = ps;
        bus.branch_jump_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic sf, input logic sd, input logic fd, input logic ps,
                           input logic [31:0] tgt, input logic [31:0] pcf,
                           input logic [31:0] pcd, input logic [31:0] instr,
                           input logic drain, input logic halted, input logic [31:0] cnt);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fd = fd; v.ps = ps; v.tgt = tgt;
        v.pcf = pcf; v.pcd = pcd; v.instr = instr;
        v.drain = drain; v.halted = halted; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // One-cycle reset with idle inputs, then release.
    task automatic quick_reset(input logic [31:0] lpc);
        reset = 1'b1;
        bus.last_pc = lpc;
        drive(0, 0, 0, 0, 32'h0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 32'h0);
        bus.last_pc = 32'h8;

        // Reset held 5 cycles under random inputs.
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            step();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        check("rst.PCF", bus.PCF, 32'h0);
        check("rst.InstrD", bus.InstrD, 32'h0);
        check("rst.halted", {31'h0, bus.halted}, 32'h0);
        check("rst.fetch_count", bus.fetch_count, 32'h0);
        check("rst.drain_active", {31'h0, bus.drain_active}, 32'h0);

        // Straight-line fetch with a 2-cycle stall at PCF=4, last_pc=8.
        add_vec(0,0,0,0,0, 32'h4, 32'h0, instr_of(32'h0), 0,0, 1);
        add_vec(1,1,0,0,0, 32'h4, 32'h0, instr_of(32'h0), 0,0, 1);
        add_vec(1,1,0,0,0, 32'h4, 32'h0, instr_of(32'h0), 0,0, 1);
        add_vec(0,0,0,0,0, 32'h8, 32'h4, instr_of(32'h4), 0,0, 2);
        add_vec(0,0,0,0,0, 32'hC, 32'h8, instr_of(32'h8), 1,0, 3);
        for (int k = 1; k <= 9; k++)
            add_vec(0,0,0,0,0, 32'hC + 4*k, 32'hC + 4*(k-1), 32'h0, 1,0, 3);
        add_vec(0,0,0,0,0, 32'h34, 32'h30, 32'h0, 0,1, 3);
        add_vec(0,0,0,0,0, 32'h34, 32'h34, 32'h0, 0,1, 3);
        add_vec(1,1,0,1,32'h40, 32'h34, 32'h34, 32'h0, 0,1, 3);
        add_vec(0,0,1,0,0, 32'h34, 32'h0, 32'h0, 0,1, 3);
        add_vec(0,0,0,0,0, 32'h34, 32'h34, 32'h0, 0,1, 3);

        foreach (vecs[i]) begin
            drive(vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].ps, vecs[i].tgt);
            step();
            check($sformatf("v%0d.PCF", i), bus.PCF, vecs[i].pcf);
            check($sformatf("v%0d.PCD", i), bus.PCD, vecs[i].pcd);
            check($sformatf("v%0d.InstrD", i), bus.InstrD, vecs[i].instr);
            check($sformatf("v%0d.drain", i), {31'h0, bus.drain_active}, {31'h0, vecs[i].drain});
            check($sformatf("v%0d.halted", i), {31'h0, bus.halted}, {31'h0, vecs[i].halted});
            check($sformatf("v%0d.count", i), bus.fetch_count, vecs[i].cnt);
        end
        drive(0, 0, 0, 0, 32'h0);

        // Reset while halted: full return to RUN, fetch resumes.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rh.PCF", bus.PCF, 32'h0);
        check("rh.halted", {31'h0, bus.halted}, 32'h0);
        check("rh.drain", {31'h0, bus.drain_active}, 32'h0);
        check("rh.count", bus.fetch_count, 32'h0);
        step();
        check("rh.resume.PCF", bus.PCF, 32'h4);
        check("rh.resume.InstrD", bus.InstrD, instr_of(32'h0));
        check("rh.resume.pc_plus4D", bus.pc_plus4D, 32'h4);
        check("rh.resume.pc_plus4F", bus.pc_plus4F, 32'h8);

        // Redirect with flush at PCF=0xC.
        quick_reset(32'h100);
        for (int i = 0; i < 3; i++) step();
        check("rd.pre.PCF", bus.PCF, 32'hC);
        drive(0, 0, 1, 1, 32'h40);
        step();
        check("rd.PCF", bus.PCF, 32'h40);
        check("rd.InstrD", bus.InstrD, 32'h0);
        check("rd.PCD", bus.PCD, 32'h0);
        check("rd.count", bus.fetch_count, 32'h3);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("rd.next.PCD", bus.PCD, 32'h40);
        check("rd.next.InstrD", bus.InstrD, instr_of(32'h40));
        check("rd.next.count", bus.fetch_count, 32'h4);

        // PCF==last_pc with redirect, then while stalled: no drain entry.
        quick_reset(32'h4);
        step();
        drive(0, 0, 0, 1, 32'h20);
        step();
        check("lp.redir.PCF", bus.PCF, 32'h20);
        check("lp.redir.drain", {31'h0, bus.drain_active}, 32'h0);
        drive(0, 0, 0, 1, 32'h4);
        step();
        drive(1, 1, 0, 0, 32'h0);
        step();
        check("lp.stall.PCF", bus.PCF, 32'h4);
        check("lp.stall.drain", {31'h0, bus.drain_active}, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("lp.go.drain", {31'h0, bus.drain_active}, 32'h1);

        // Redirect out of DRAIN after 3 bubbles; re-entry needs a full drain.
        quick_reset(32'h8);
        for (int i = 0; i < 3; i++) step();
        check("dr.enter", {31'h0, bus.drain_active}, 32'h1);
        for (int i = 0; i < 3; i++) step();
        drive(0, 0, 0, 1, 32'h4);
        step();
        check("dr.redir.PCF", bus.PCF, 32'h4);
        check("dr.redir.drain", {31'h0, bus.drain_active}, 32'h0);
        check("dr.redir.InstrD", bus.InstrD, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("dr.refetch.InstrD", bus.InstrD, instr_of(32'h4));
        step();
        check("dr.reenter", {31'h0, bus.drain_active}, 32'h1);
        check("dr.reenter.count", bus.fetch_count, 32'h5);
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("dr.b%0d.halted", k), {31'h0, bus.halted}, 32'h0);
        end
        step();
        check("dr.halted", {31'h0, bus.halted}, 32'h1);
        check("dr.halt.PCF", bus.PCF, 32'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Feeds the decode stage. Drives the instruction-memory address and consumes redirect and stall/flush signals from execute and the hazard unit.
- Contains a synthesizable end-of-program drain FSM. After the last program word is fetched, it injects NOP bubbles for a fixed number of cycles, then asserts halted.

Parameters:
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PCF value after reset
- NOP_INSTR, 32'h0000_0000, encoding injected as a bubble
- DRAIN_CYCLES, 10, NOP cycles accepted into IF/ID before halt

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- StallF  in  1  hold PCF (hazard unit)
- StallD  in  1  hold IF/ID (hazard unit)
- FlushD  in  1  load NOP into IF/ID
- pc_select  in  1  1 = redirect to branch_jump_target (from execute)
- branch_jump_target  in  XLEN  redirect address
- last_pc  in  XLEN  address of final program word; must be stable while reset=0
- InstrF  in  32  instruction-memory read data for PCF (combinational read)
- PCF  out  XLEN  current fetch address to instruction memory
- pc_plus4F  out  XLEN  PCF+4
- PCD  out  XLEN  IF/ID PC
- InstrD  out  32  IF/ID instruction
- pc_plus4D  out  XLEN  IF/ID PC+4
- drain_active  out  1  FSM in DRAIN
- halted  out  1  FSM in HALT (sticky until reset)
- fetch_count  out  32  non-bubble instructions accepted into IF/ID

Behaviour:
- Reset (sync, dominates all other inputs):
  - PCF=RESET_PC; PCD=0; pc_plus4D=0; InstrD=NOP_INSTR; fetch_count=0
  - state=RUN; drain counter=0; drain_active=0; halted=0
- pc_plus4F = PCF+4, modulo 2^XLEN; wraps silently.
- next_pc = pc_select ? branch_jump_target : pc_plus4F.
- PCF update:
  - Loads next_pc when !StallF and state != HALT.
  - pc_select takes priority over StallF (redirect always lands).
  - In HALT, PCF is frozen.
- Fetched word: fetch_word = (state==RUN) ? InstrF : NOP_INSTR.
- IF/ID register, priority FlushD > StallD > load:
  - FlushD: InstrD=NOP_INSTR, PCD=0, pc_plus4D=0.
  - StallD: all fields hold.
  - Otherwise: load {PCF, fetch_word, pc_plus4F}.
  - Latency: one cycle from PCF to PCD/InstrD.
- fetch_count increments by 1 (wrapping) when state==RUN, !StallD, !FlushD and fetch_word != NOP_INSTR.
- FSM states:
  - RUN:
    - -> DRAIN when PCF==last_pc, !StallF, !StallD, !FlushD and !pc_select. The last word is accepted this cycle and the counter clears to 0.
    - Otherwise stays in RUN.
  - DRAIN:
    - Bubbles only. The counter increments on each cycle with !StallD.
    - pc_select=1 (redirect from an older in-flight branch or jump) -> RUN. Counter clears; PCF=branch_jump_target.
    - Otherwise -> HALT on the cycle the counter reaches DRAIN_CYCLES-1 and increments.
    - pc_select outranks drain completion in the same cycle.
  - HALT:
    - Terminal until reset. pc_select, StallF and StallD are ignored.
    - IF/ID keeps accepting NOP_INSTR; FlushD is still honoured.
- Boundaries:
  - PCF==last_pc while stalled: no transition until the word is accepted.
  - PCF==last_pc with pc_select in the same cycle: stays in RUN.
  - DRAIN_CYCLES must be >=1; a value of 1 halts after a single bubble.
  - Reset mid-DRAIN or in HALT: full reset, back to RUN.
- Outputs are registered except pc_plus4F, drain_active and halted. The last two decode state directly.

Decomposition:
- Package rv_pipe_pkg holds:
  - NOP_INSTR and RESET_PC defaults
  - fetch-FSM state enum: RUN=2'd0, DRAIN=2'd1, HALT=2'd2
  - XLEN constant
- One sub-module, if_id_reg: the IF/ID register with sync reset, flush and stall.
- The FSM, PC register and counters stay in fetch_stage.

Test Plan:
- Reset: hold reset 5 cycles with random inputs -> PCF=0, InstrD=0, halted=0, fetch_count=0 on the first cycle after release.
- Straight line:
  - Setup: IMEM 0x0/0x4/0x8 nonzero, last_pc=8, no stalls.
  - Required: PCF 0→4→8. drain_active rises the cycle after PCF=8. InstrD=0 for all following cycles. halted=1 exactly 10 cycles after DRAIN entry. PCF is frozen from then on. fetch_count=3.
- Stall: StallF=StallD=1 for 2 cycles at PCF=4 -> PCF, PCD and InstrD hold for 2 cycles, then resume at 8. fetch_count is unaffected by the stalled cycles.
- Redirect: pc_select=1, target=0x40, FlushD=1 at PCF=0xC -> next cycle PCF=0x40, InstrD=0, PCD=0.
- Redirect in DRAIN: after 3 drain bubbles, pc_select=1 with target=0x4 -> state RUN, PCF=0x4, counter 0. Later re-entry to DRAIN requires the full 10 bubbles before halted.
- Reset in HALT: assert reset 1 cycle -> PCF=0, halted=0, drain_active=0, fetch_count=0. Normal fetch resumes.
